spi_tx_arbiter: RTL and testbench
=================================

# spi_tx_arbiter

Round-robin arbiter that shares one SPI byte transmitter (spi_master_tx_mode2) between N_REQ independent byte sources. Each requester presents a byte and a level request; the arbiter selects one, drives the transmitter's request/data inputs, tracks its busy flag through one frame, and returns a one-cycle acknowledge. It sits directly in front of the transmitter's In_tx_req / In_tx_data / Out_tx_busy pins.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 64, max cycles to wait for transmitter busy to rise after request (used only with SPI_ARB_TIMEOUT_EN)
- In_clk  input  1  system clock, all logic on rising edge
- In_rst  input  1  reset, asynchronous, active-high
- In_req  input  N_REQ  per-requester level request, held until Out_ack
- In_data  input  8*N_REQ  per-requester byte; requester i at bits [8i+7:8i]
- Out_grant  output  N_REQ  one-hot, current owner; 0 when idle
- Out_ack  output  N_REQ  one-cycle pulse to owner at frame end (or timeout)
- Out_err  output  1  one-cycle pulse with Out_ack on timeout
- Out_busy  output  1  high while not in IDLE
- Out_tx_req  output  1  to transmitter In_tx_req
- Out_tx_data  output  8  to transmitter In_tx_data, stable while Out_tx_req or transmitter busy
- In_tx_busy  input  1  from transmitter Out_tx_busy

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: if any In_req bit set and In_tx_busy==0, pick winner = first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0); register Out_grant, Out_tx_data = winner's byte; go START.
- IDLE with In_tx_busy==1 (e.g. after arbiter-only reset): no grant until busy is low.
- START: Out_tx_req=1. On In_tx_busy sampled 1 -> WAIT, Out_tx_req cleared from the next cycle.
- WAIT: Out_tx_req=0; on In_tx_busy sampled 0 -> DONE.
- DONE: Out_ack[winner]=1 for one cycle; rr_ptr = winner+1 mod N_REQ; Out_grant cleared; -> IDLE.
- Requester must drop In_req in the ack cycle; a request still high in the following IDLE cycle is treated as a new request and competes fairly (lowest priority after rr_ptr update).
- In_data is sampled only at grant; later changes do not affect the frame in flight.
- Requests dropping before ack while granted: ignored, frame completes normally.
- Reset: state IDLE, rr_ptr 0, all outputs 0 (Out_tx_data 8'h00).

## Timing
- Arbitration latency: In_req rising in IDLE -> Out_grant and Out_tx_data valid next edge, Out_tx_req high same cycle (registered, 1 cycle).
- Out_tx_req remains high until the cycle after In_tx_busy is first sampled high.
- Out_ack asserted the cycle after In_tx_busy is sampled low in WAIT.
- Minimum gap between consecutive Out_tx_req pulses: 2 cycles (DONE + IDLE).
- Throughput: one byte per transmitter frame + 3 cycles.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: cycle counter runs in START; if In_tx_busy not seen within TIMEOUT_CYC cycles, Out_tx_req drops, go DONE with Out_ack and Out_err pulsed together; rr_ptr advances as normal.
- Not defined: no counter, START waits indefinitely; Out_err tied 0.

## Structure
- Package spi_arb_pkg: state enum (IDLE/START/WAIT/DONE), max N_REQ constant 8, byte width constant 8.
- One sub-module: spi_rr_pick (combinational round-robin picker: req vector + ptr -> one-hot winner + index).
- Transmitter is instantiated by the parent, not inside this block.

## Test plan
- Single request: In_req=4'b0010, In_data[15:8]=8'h12 -> grant 4'b0010 next cycle, Out_tx_data=8'h12, one frame on MOSI (0x12), Out_ack[1] pulse after busy falls.
- All four requesting from reset, bytes 8'hA0..8'hA3 -> serviced order 0,1,2,3, MOSI bytes A0,A1,A2,A3, one ack each.
- Fairness: requester 0 re-raises immediately after ack while 2 waits -> 2 served before 0 again.
- Data change after grant: In_data for owner changed 8'h55->8'hAA mid-frame -> transmitted byte 0x55.
- Async reset asserted in WAIT -> all outputs 0 immediately; with transmitter still busy, no new Out_tx_req until In_tx_busy low.
- SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, In_tx_busy stuck 0 -> Out_ack and Out_err pulse 17 cycles after Out_tx_req rose; next requester then granted.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
package spi_arb_pkg;

  localparam int MAX_N_REQ = 8;
  localparam int BYTE_W    = 8;
  localparam int IDX_W     = $clog2(MAX_N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the farthest slot back to the pointer so the nearest hit is written last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = |i_req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_idx = IDX_W'((int'(i_ptr) + k) % N_REQ);
        o_grant = '0;
        o_grant[(int'(i_ptr) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI byte transmitter among N_REQ sources.
// Optional start-phase timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      In_clk,
  input  logic                      In_rst,
  input  logic [N_REQ-1:0]          In_req,
  input  logic [BYTE_W*N_REQ-1:0]   In_data,
  output logic [N_REQ-1:0]          Out_grant,
  output logic [N_REQ-1:0]          Out_ack,
  output logic                      Out_err,
  output logic                      Out_busy,
  output logic                      Out_tx_req,
  output logic [BYTE_W-1:0]         Out_tx_data,
  input  logic                      In_tx_busy
);

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_ack;
  logic                r_tx_req;
  logic [BYTE_W-1:0]   r_tx_data;

  logic [N_REQ-1:0]    w_win_oh;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_win_vld;
  logic [BYTE_W-1:0]   w_win_byte;
  logic [IDX_W-1:0]    w_ptr_next;

  spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (In_req),
    .i_ptr   (r_ptr),
    .o_grant (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_vld)
  );

  always_comb begin
    w_win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_idx == IDX_W'(i)) w_win_byte = In_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign w_ptr_next = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
`endif

  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_tx_req  <= 1'b0;
      r_tx_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // A transmitter still busy from before a reset blocks new grants.
          if (w_win_vld && !In_tx_busy) begin
            r_grant   <= w_win_oh;
            r_owner   <= w_win_idx;
            r_tx_data <= w_win_byte;
            r_tx_req  <= 1'b1;
            r_state   <= ST_START;
`ifdef SPI_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        ST_START: begin
          if (In_tx_busy) begin
            r_tx_req <= 1'b0;
            r_state  <= ST_WAIT;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
            r_tx_req <= 1'b0;
            r_ack    <= r_grant;
            r_err    <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_WAIT: begin
          if (!In_tx_busy) begin
            r_ack   <= r_grant;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Out_grant   = r_grant;
  assign Out_ack     = r_ack;
  assign Out_busy    = (r_state != ST_IDLE);
  assign Out_tx_req  = r_tx_req;
  assign Out_tx_data = r_tx_data;
`ifdef SPI_ARB_TIMEOUT_EN
  assign Out_err     = r_err;
`else
  assign Out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: transmitter stand-in, rule-based model, directed and random traffic.
module tb_spi_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic           tx_busy;
  logic [N-1:0]   o_grant;
  logic [N-1:0]   o_ack;
  logic           o_err;
  logic           o_busy;
  logic           o_tx_req;
  logic [7:0]     o_tx_data;

  spi_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .In_clk      (clk),
    .In_rst      (rst),
    .In_req      (req),
    .In_data     (data),
    .Out_grant   (o_grant),
    .Out_ack     (o_ack),
    .Out_err     (o_err),
    .Out_busy    (o_busy),
    .Out_tx_req  (o_tx_req),
    .Out_tx_data (o_tx_data),
    .In_tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_owner = -1;  // requester currently holding the transmitter, -1 if none
  int         m_phase = 0;   // 0 free, 1 request raised, 2 frame running, 3 acknowledging
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic       m_txreq = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [N-1:0] m_ack = '0;
  logic       m_err = 1'b0;
  logic [7:0] exp_q[$];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int o);
    return (o < 0) ? 32'd0 : (32'd1 << o);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_phase <= 0; m_ptr <= 0; m_cnt <= 0;
      m_txreq <= 1'b0; m_data <= 8'h00; m_ack <= '0; m_err <= 1'b0;
      exp_q.delete();
    end else begin
      int w;
      logic [N-1:0] a;
      a = '0;
      m_ack <= '0;
      m_err <= 1'b0;
      case (m_phase)
        0: if (req != 0 && !tx_busy) begin
          w = pick(req, m_ptr);
          m_owner <= w;
          m_data  <= data[8*w +: 8];
          exp_q.push_back(data[8*w +: 8]);
          m_txreq <= 1'b1;
          m_cnt   <= 0;
          m_phase <= 1;
        end
        1: if (tx_busy) begin
          m_txreq <= 1'b0;
          m_phase <= 2;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (m_cnt == TO) begin
          a[m_owner] = 1'b1;
          m_ack   <= a;
          m_err   <= 1'b1;
          m_txreq <= 1'b0;
          m_phase <= 3;
          void'(exp_q.pop_front());
        end else m_cnt <= m_cnt + 1;
`endif
        2: if (!tx_busy) begin
          a[m_owner] = 1'b1;
          m_ack   <= a;
          m_phase <= 3;
        end
        default: begin
          m_ptr   <= (m_owner + 1) % N;
          m_owner <= -1;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("grant",   32'(o_grant),   onehot(m_owner));
    chk("ack",     32'(o_ack),     32'(m_ack));
    chk("err",     32'(o_err),     32'(m_err));
    chk("busy",    32'(o_busy),    32'(m_owner >= 0));
    chk("tx_req",  32'(o_tx_req),  32'(m_txreq));
    chk("tx_data", 32'(o_tx_data), 32'(m_data));
  end

  // ---------------- transmitter stand-in ----------------
  bit   tx_en = 1'b1;
  bit   tx_force = 1'b0;
  bit   tx_act = 1'b0;
  int   tx_lat = 0;
  int   tx_len = 0;
  logic [7:0] last_mosi = 8'h00;
  logic [7:0] mosi_log[$];

  always @(negedge clk) begin
    if (tx_force) begin
      tx_busy = 1'b1;
      tx_act  = 1'b0;
    end else if (tx_act) begin
      if (tx_len == 0) begin
        tx_busy = 1'b0;
        tx_act  = 1'b0;
      end else tx_len--;
    end else begin
      tx_busy = 1'b0;
      if (tx_en && o_tx_req) begin
        if (tx_lat == 0) begin
          tx_busy   = 1'b1;
          tx_act    = 1'b1;
          tx_len    = $urandom_range(2, 8);
          last_mosi = o_tx_data;
          mosi_log.push_back(o_tx_data);
          if (exp_q.size() == 0) chk("mosi_unexpected", 32'(o_tx_data), 32'hFFFF_FFFF);
          else chk("mosi_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end else tx_lat--;
      end else tx_lat = $urandom_range(0, 2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input string nm, output logic [N-1:0] a);
    int n = 0;
    while (o_ack == 0 && n < 400) begin @(negedge clk); n++; end
    if (o_ack == 0) begin
      checks++; errors++;
      $display("FAIL %s: no ack within 400 cycles", nm);
    end
    a = o_ack;
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (o_grant == 0 && n < 400) begin @(negedge clk); n++; end
    if (o_grant == 0) begin
      checks++; errors++;
      $display("FAIL %s: no grant within 400 cycles", nm);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] a;
    int order[$];
    int n;
    rst = 1'b1; req = '0; data = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_txreq", 32'(o_tx_req), 32'h0);
    chk("rst_txdata", 32'(o_tx_data), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    rst = 1'b0;

    // single request
    @(negedge clk); req = 4'b0010; data[15:8] = 8'h12;
    @(negedge clk);
    chk("single_grant", 32'(o_grant), 32'h2);
    chk("single_txdata", 32'(o_tx_data), 32'h12);
    chk("single_txreq", 32'(o_tx_req), 32'h1);
    wait_ack("single", a);
    chk("single_ack", 32'(a), 32'h2);
    chk("single_mosi", 32'(last_mosi), 32'h12);
    req = '0;
    @(negedge clk);

    // all four from reset
    pulse_reset();
    req = 4'b1111; data = 32'hA3A2_A1A0;
    mosi_log.delete();
    for (int k = 0; k < 4; k++) begin
      wait_ack("all4", a);
      for (int i = 0; i < N; i++) if (a[i]) order.push_back(i);
      req = req & ~a;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk("all4_order", 32'(k < order.size() ? order[k] : -1), 32'(k));
      chk("all4_mosi", 32'(k < mosi_log.size() ? mosi_log[k] : 8'h00), 32'hA0 + 32'(k));
    end

    // fairness: requester 0 keeps requesting while 2 waits
    req = 4'b0101; data[7:0] = 8'h01; data[23:16] = 8'h02;
    wait_ack("fair0", a);
    chk("fair_first", 32'(a), 32'h1);
    @(negedge clk);
    wait_grant("fair2");
    chk("fair_second", 32'(o_grant), 32'h4);
    wait_ack("fair2", a);
    req[2] = 1'b0;
    @(negedge clk);
    wait_ack("fair0b", a);
    chk("fair_third", 32'(a), 32'h1);
    req = '0;
    @(negedge clk);

    // data change after grant
    req = 4'b1000; data[31:24] = 8'h55;
    wait_grant("dchg");
    n = 0;
    while (!tx_busy && n < 100) begin @(negedge clk); n++; end
    data[31:24] = 8'hAA;
    wait_ack("dchg", a);
    chk("dchg_mosi", 32'(last_mosi), 32'h55);
    chk("dchg_hold", 32'(o_tx_data), 32'h55);
    req = '0;
    @(negedge clk);

    // asynchronous reset during the running frame
    req = 4'b0001; data[7:0] = 8'h3C;
    n = 0;
    while (!(o_busy && !o_tx_req && tx_busy) && n < 100) begin @(negedge clk); n++; end
    chk("arst_in_wait", 32'(o_busy && !o_tx_req), 32'h1);
    tx_force = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 32'(o_grant), 32'h0);
    chk("arst_busy", 32'(o_busy), 32'h0);
    chk("arst_txreq", 32'(o_tx_req), 32'h0);
    chk("arst_txdata", 32'(o_tx_data), 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("arst_blocked", 32'(o_tx_req), 32'h0);
    end
    tx_force = 1'b0;
    wait_ack("arst_after", a);
    chk("arst_after_ack", 32'(a), 32'h1);
    req = '0;
    @(negedge clk);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (o_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          data[8*i +: 8] = 8'($urandom);
        end else if (o_grant[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) data[8*i +: 8] = 8'($urandom);
      end
    end
    req = '0;
    n = 0;
    while (o_busy && n < 400) begin @(negedge clk); n++; end
    chk("drain_idle", 32'(o_busy), 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
    // transmitter never answers
    tx_en = 1'b0;
    @(negedge clk);
    pulse_reset();
    req = 4'b0110; data[15:8] = 8'h77; data[23:16] = 8'h88;
    n = 0;
    while (!o_tx_req && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (o_ack == 0 && n < 100) begin @(negedge clk); n++; end
    chk("to_latency", 32'(n), 32'd17);
    chk("to_ack", 32'(o_ack), 32'h2);
    chk("to_err", 32'(o_err), 32'h1);
    req[1] = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    wait_grant("to_next");
    chk("to_next_grant", 32'(o_grant), 32'h4);
    wait_ack("to_next", a);
    req = '0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
